// File: rtl/bp_be_pkg.sv
// Shared types for the BE stride prefetcher: FSM states, trigger record, page geometry
// and the processor-configuration lookup used to size the datapath.
`ifndef BP_BE_PKG_SV
`define BP_BE_PKG_SV

`define BP_BE_PF_TRIGGER_WIDTH(vaddr_mp, degree_mp) ((3 * (vaddr_mp)) + (degree_mp))

package bp_be_pkg;

  typedef enum logic [0:0] {e_bp_default_cfg} bp_params_e;

  localparam int pf_vaddr_width_gp       = 39;
  localparam int pf_dcache_block_width_gp = 512;
  localparam int pf_degree_width_gp      = 4;
  localparam int pf_page_offset_gp       = 12;

  typedef enum logic [1:0] {e_idle, e_calc, e_req} bp_be_pf_state_e;

  // Stride is stored already sign-extended to the vaddr width.
  typedef struct packed {
    logic [pf_vaddr_width_gp-1:0]  pc;
    logic [pf_vaddr_width_gp-1:0]  addr;
    logic [pf_vaddr_width_gp-1:0]  stride;
    logic [pf_degree_width_gp-1:0] degree;
  } bp_be_pf_trigger_s;

  function automatic int bp_vaddr_width(bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return pf_vaddr_width_gp;
      default:          return pf_vaddr_width_gp;
    endcase
  endfunction

  function automatic int bp_dcache_block_width(bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return pf_dcache_block_width_gp;
      default:          return pf_dcache_block_width_gp;
    endcase
  endfunction

endpackage

`endif

// File: rtl/bp_be_pf_trigger_buffer.sv
// One-entry overwrite buffer holding the newest unconsumed stride trigger.
// Priority: clear > set > consume.
module bp_be_pf_trigger_buffer #(
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               set_i,
  input  logic [width_p-1:0] data_i,
  input  logic               consume_i,
  input  logic               clear_i,
  output logic               v_o,
  output logic               v_n_o,
  output logic [width_p-1:0] data_o
);

  logic               v_q, v_d;
  logic [width_p-1:0] data_q, data_d;

  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    if (clear_i) begin
      v_d = 1'b0;
    end else if (set_i) begin
      v_d    = 1'b1;
      data_d = data_i;
    end else if (consume_i) begin
      v_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v_q    <= 1'b0;
      data_q <= '0;
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
    end
  end

  assign v_o    = v_q;
  assign v_n_o  = v_d;
  assign data_o = data_q;

endmodule

// File: rtl/bp_be_stride_prefetcher.sv
// Turns stride triggers into short streams of block-aligned prefetch requests that
// never cross a 4 KiB page. Optional duplicate-block suppression: BP_BE_PREFETCH_DEDUP_EN.
module bp_be_stride_prefetcher
  import bp_be_pkg::*;
#(
  parameter bp_params_e bp_params_p      = e_bp_default_cfg,
  parameter int         stride_width_p   = 8,
  parameter int         degree_p         = 2,
  parameter int         confirm_degree_p = 4,
  localparam int        vaddr_width_p        = bp_vaddr_width(bp_params_p),
  localparam int        dcache_block_width_p = bp_dcache_block_width(bp_params_p)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      flush_i,
  input  logic                      stride_v_i,
  input  logic [stride_width_p-1:0] stride_i,
  input  logic [vaddr_width_p-1:0]  pc_i,
  input  logic [vaddr_width_p-1:0]  addr_i,
  input  logic                      start_discovery_i,
  input  logic                      confirm_discovery_i,
  output logic                      pf_v_o,
  output logic [vaddr_width_p-1:0]  pf_addr_o,
  input  logic                      pf_ready_and_i,
  output logic                      busy_o
);

  localparam int blk_off_lp = $clog2(dcache_block_width_p / 8);
  localparam int blk_w_lp   = vaddr_width_p - blk_off_lp;
  localparam int page_w_lp  = vaddr_width_p - pf_page_offset_gp;
  localparam int trig_w_lp  = `BP_BE_PF_TRIGGER_WIDTH(vaddr_width_p, pf_degree_width_gp);

  bp_be_pf_trigger_s trig_in, pend;
  logic [trig_w_lp-1:0] pend_raw;
  logic pend_v, pend_v_n, pend_set, pend_consume;
  logic unused_pc;

  always_comb begin
    trig_in        = '0;
    trig_in.pc     = pc_i;
    trig_in.addr   = addr_i;
    trig_in.stride = {{(vaddr_width_p-stride_width_p){stride_i[stride_width_p-1]}}, stride_i};
    if (confirm_discovery_i)    trig_in.degree = pf_degree_width_gp'(confirm_degree_p);
    else if (start_discovery_i) trig_in.degree = pf_degree_width_gp'(1);
    else                        trig_in.degree = pf_degree_width_gp'(degree_p);
  end

  assign pend_set = stride_v_i & (stride_i != '0);

  bp_be_pf_trigger_buffer #(.width_p(trig_w_lp)) u_trig_buf (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .set_i     (pend_set),
    .data_i    (trig_in),
    .consume_i (pend_consume),
    .clear_i   (flush_i),
    .v_o       (pend_v),
    .v_n_o     (pend_v_n),
    .data_o    (pend_raw)
  );

  assign pend      = bp_be_pf_trigger_s'(pend_raw);
  assign unused_pc = ^pend.pc;

  bp_be_pf_state_e state_q, state_d;
  logic [vaddr_width_p-1:0]      base_q, base_d, stride_q, stride_d, pf_addr_q, pf_addr_d;
  logic [vaddr_width_p-1:0]      next_addr;
  logic [blk_w_lp-1:0]           next_blk;
  logic [page_w_lp-1:0]          page_q, page_d;
  logic [pf_degree_width_gp-1:0] cnt_q, cnt_d;
  logic                          pf_v_q, busy_q, load;
`ifdef BP_BE_PREFETCH_DEDUP_EN
  logic [blk_w_lp-1:0]           last_blk_q, last_blk_d;
`endif

  assign next_addr = base_q + stride_q;
  assign next_blk  = next_addr[vaddr_width_p-1:blk_off_lp];

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    stride_d     = stride_q;
    cnt_d        = cnt_q;
    page_d       = page_q;
    pf_addr_d    = pf_addr_q;
    load         = 1'b0;
`ifdef BP_BE_PREFETCH_DEDUP_EN
    last_blk_d   = last_blk_q;
`endif
    case (state_q)
      e_idle: begin
        if (pend_v) begin
          load    = 1'b1;
          state_d = e_calc;
        end
      end
      e_calc: begin
        // A waiting trigger replaces whatever remains of the current stream.
        if (pend_v) begin
          load = 1'b1;
        end else begin
          base_d = next_addr;
          cnt_d  = cnt_q - 1'b1;
          if (next_addr[vaddr_width_p-1:pf_page_offset_gp] != page_q) begin
            state_d = e_idle;
`ifdef BP_BE_PREFETCH_DEDUP_EN
          end else if (next_blk == last_blk_q) begin
            state_d = (cnt_d == '0) ? e_idle : e_calc;
`endif
          end else begin
            pf_addr_d  = {next_blk, {blk_off_lp{1'b0}}};
            state_d    = e_req;
`ifdef BP_BE_PREFETCH_DEDUP_EN
            last_blk_d = next_blk;
`endif
          end
        end
      end
      e_req: begin
        if (pf_ready_and_i) begin
          if (pend_v) begin
            load    = 1'b1;
            state_d = e_calc;
          end else if (cnt_q != '0) begin
            state_d = e_calc;
          end else begin
            state_d = e_idle;
          end
        end
      end
      default: state_d = e_idle;
    endcase

    if (load) begin
      base_d     = pend.addr;
      stride_d   = pend.stride;
      cnt_d      = pend.degree;
      page_d     = pend.addr[vaddr_width_p-1:pf_page_offset_gp];
`ifdef BP_BE_PREFETCH_DEDUP_EN
      last_blk_d = pend.addr[vaddr_width_p-1:blk_off_lp];
`endif
    end

    if (flush_i) state_d = e_idle;
  end

  assign pend_consume = load & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= e_idle;
      base_q     <= '0;
      stride_q   <= '0;
      cnt_q      <= '0;
      page_q     <= '0;
      pf_addr_q  <= '0;
      pf_v_q     <= 1'b0;
      busy_q     <= 1'b0;
`ifdef BP_BE_PREFETCH_DEDUP_EN
      last_blk_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      stride_q   <= stride_d;
      cnt_q      <= cnt_d;
      page_q     <= page_d;
      pf_addr_q  <= pf_addr_d;
      pf_v_q     <= (state_d == e_req);
      busy_q     <= (state_d != e_idle) | pend_v_n;
`ifdef BP_BE_PREFETCH_DEDUP_EN
      last_blk_q <= last_blk_d;
`endif
    end
  end

  assign pf_v_o    = pf_v_q;
  assign pf_addr_o = pf_addr_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_bp_be_stride_prefetcher.sv
// Directed bench: expected prefetch addresses are queued with each trigger and a
// negedge monitor pops/compares them on every accepted request.
module tb_bp_be_stride_prefetcher;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        stride_v_i = 1'b0;
  logic [7:0]  stride_i = '0;
  logic [38:0] pc_i = '0;
  logic [38:0] addr_i = '0;
  logic        start_discovery_i = 1'b0;
  logic        confirm_discovery_i = 1'b0;
  logic        pf_v_o;
  logic [38:0] pf_addr_o;
  logic        pf_ready_and_i = 1'b0;
  logic        busy_o;

  int nvec = 0;
  int nmis = 0;
  logic [38:0] exp_q[$];

  always #5 clk_i = ~clk_i;

  bp_be_stride_prefetcher dut (
    .clk_i               (clk_i),
    .reset_i             (reset_i),
    .flush_i             (flush_i),
    .stride_v_i          (stride_v_i),
    .stride_i            (stride_i),
    .pc_i                (pc_i),
    .addr_i              (addr_i),
    .start_discovery_i   (start_discovery_i),
    .confirm_discovery_i (confirm_discovery_i),
    .pf_v_o              (pf_v_o),
    .pf_addr_o           (pf_addr_o),
    .pf_ready_and_i      (pf_ready_and_i),
    .busy_o              (busy_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted request must match the oldest expectation.
  always @(negedge clk_i) begin
    if (!reset_i && pf_v_o && pf_ready_and_i) begin
      nvec++;
      if (exp_q.size() == 0) begin
        nmis++;
        $display("FAIL unexpected_req got %h expected none", pf_addr_o);
      end else begin
        logic [38:0] e;
        e = exp_q.pop_front();
        if (pf_addr_o !== e) begin
          nmis++;
          $display("FAIL req_addr got %h expected %h", pf_addr_o, e);
        end
      end
    end
  end

  // Returns #1 after the edge that samples the trigger.
  task automatic trig(input logic [38:0] a, input logic [7:0] s, input logic st, input logic cf);
    @(posedge clk_i); #1;
    stride_v_i = 1'b1; addr_i = a; pc_i = a ^ 39'h400; stride_i = s;
    start_discovery_i = st; confirm_discovery_i = cf;
    @(posedge clk_i); #1;
    stride_v_i = 1'b0; start_discovery_i = 1'b0; confirm_discovery_i = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((busy_o || exp_q.size() != 0) && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    chk({name, "_drain"}, 64'(n < 200), 64'd1);
    repeat (2) @(negedge clk_i);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk_i);
    #1 reset_i = 1'b0;
    @(negedge clk_i);
    chk("rst_pf_v", 64'(pf_v_o), 64'd0);
    chk("rst_pf_addr", 64'(pf_addr_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);

    // Basic stream with cycle-accurate latency checks
    pf_ready_and_i = 1'b1;
    exp_q.push_back(39'h1040); exp_q.push_back(39'h1080);
    trig(39'h1000, 8'h40, 1'b0, 1'b0);
    @(negedge clk_i);
    chk("basic_t0_v", 64'(pf_v_o), 64'd0);
    chk("basic_t0_busy", 64'(busy_o), 64'd1);
    repeat (2) @(negedge clk_i);
    chk("basic_t2_v", 64'(pf_v_o), 64'd1);
    chk("basic_t2_addr", 64'(pf_addr_o), 64'h1040);
    @(negedge clk_i);
    chk("basic_t3_v", 64'(pf_v_o), 64'd0);
    @(negedge clk_i);
    chk("basic_t4_addr", 64'(pf_addr_o), 64'h1080);
    @(negedge clk_i);
    chk("basic_t5_busy", 64'(busy_o), 64'd0);
    drain("basic");

    // Negative stride, confirmed: degree 4
    exp_q.push_back(39'h2380); exp_q.push_back(39'h2300);
    exp_q.push_back(39'h2280); exp_q.push_back(39'h2200);
    trig(39'h2400, 8'h80, 1'b0, 1'b1);
    drain("neg");

    // Start discovery only: degree 1
    exp_q.push_back(39'h3040);
    trig(39'h3000, 8'h40, 1'b1, 1'b0);
    drain("start");

    // Both flags: confirm wins
    exp_q.push_back(39'h4040); exp_q.push_back(39'h4080);
    exp_q.push_back(39'h40C0); exp_q.push_back(39'h4100);
    trig(39'h4000, 8'h40, 1'b1, 1'b1);
    drain("both");

    // Page cross suppresses 0x2000
    exp_q.push_back(39'h1FC0);
    trig(39'h1F80, 8'h40, 1'b0, 1'b0);
    drain("page");

    // Zero stride ignored
    trig(39'h5000, 8'h00, 1'b0, 1'b0);
    @(negedge clk_i);
    chk("zero_busy", 64'(busy_o), 64'd0);
    repeat (4) @(negedge clk_i);

    // Stall then preempt: 0x1080 must never appear
    pf_ready_and_i = 1'b0;
    exp_q.push_back(39'h1040); exp_q.push_back(39'h8040); exp_q.push_back(39'h8080);
    trig(39'h1000, 8'h40, 1'b0, 1'b0);
    repeat (3) @(negedge clk_i);
    chk("stall_v", 64'(pf_v_o), 64'd1);
    chk("stall_addr", 64'(pf_addr_o), 64'h1040);
    trig(39'h8000, 8'h40, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("stall_hold_v", 64'(pf_v_o), 64'd1);
      chk("stall_hold_addr", 64'(pf_addr_o), 64'h1040);
    end
    @(posedge clk_i); #1 pf_ready_and_i = 1'b1;
    drain("preempt");

    // Flush during the first request
    pf_ready_and_i = 1'b0;
    trig(39'h1000, 8'h40, 1'b0, 1'b0);
    repeat (3) @(negedge clk_i);
    chk("flush_pre_v", 64'(pf_v_o), 64'd1);
    @(posedge clk_i); #1 flush_i = 1'b1;
    @(posedge clk_i); #1 flush_i = 1'b0;
    @(negedge clk_i);
    chk("flush_v", 64'(pf_v_o), 64'd0);
    chk("flush_busy", 64'(busy_o), 64'd0);
    pf_ready_and_i = 1'b1;
    repeat (10) @(negedge clk_i);
    chk("flush_after_busy", 64'(busy_o), 64'd0);

    // Flush and trigger together: trigger discarded
    @(posedge clk_i); #1;
    flush_i = 1'b1; stride_v_i = 1'b1; addr_i = 39'h6000; stride_i = 8'h40;
    @(posedge clk_i); #1;
    flush_i = 1'b0; stride_v_i = 1'b0;
    @(negedge clk_i);
    chk("flushtrig_busy", 64'(busy_o), 64'd0);
    repeat (5) @(negedge clk_i);
    chk("flushtrig_busy_late", 64'(busy_o), 64'd0);

    // Duplicate blocks within the trigger block
`ifndef BP_BE_PREFETCH_DEDUP_EN
    exp_q.push_back(39'h1000); exp_q.push_back(39'h1000);
`endif
    trig(39'h1000, 8'h10, 1'b0, 1'b0);
    drain("dedup");

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/bp_be_stride_prefetcher.md
# bp_be_stride_prefetcher

Consumer of the load-stride detector's outputs in the BE checker. Accepts stride triggers (stride, PC, trigger address, discovery flags) and turns each into a short stream of block-aligned virtual-address prefetch requests. Requests go out on a valid/ready interface toward the D$ prefetch port. Streams never cross a 4 KiB page, and new triggers preempt the active stream.

## Interface
- bp_params_p, e_bp_default_cfg: supplies vaddr_width_p and dcache_block_width_p
- stride_width_p, 8: width of the signed byte stride
- degree_p, 2: steps per trigger with neither discovery flag set
- confirm_degree_p, 4: steps per trigger with confirm_discovery_i set
- clk_i  in  1  single clock
- reset_i  in  1  synchronous, active-high
- flush_i  in  1  abort the stream and clear the pending trigger
- stride_v_i  in  1  trigger valid, single-cycle pulse
- stride_i  in  stride_width_p  signed two's-complement byte stride
- pc_i  in  vaddr_width_p  PC of the triggering load
- addr_i  in  vaddr_width_p  effective address of the triggering load
- start_discovery_i  in  1  tentative stream
- confirm_discovery_i  in  1  confirmed stream
- pf_v_o  out  1  prefetch request valid
- pf_addr_o  out  vaddr_width_p  block-aligned prefetch address
- pf_ready_and_i  in  1  consumer accepts when pf_v_o & pf_ready_and_i
- busy_o  out  1  high when the state is not e_idle or a pending trigger exists

## Operation
- Trigger capture:
  - Rule: stride_v_i & (stride_i != 0) writes a one-entry pending buffer {pc, addr, sign-extended stride, degree}.
  - Overwrite: a newer trigger overwrites an unconsumed one.
  - Zero stride: stride_i == 0 is ignored.
- Degree selection:
  - confirm_discovery_i set: confirm_degree_p (confirm wins if both flags are set).
  - Else start_discovery_i set: 1.
  - Else: degree_p.
- States:
  - e_idle:
    - pending → e_calc.
    - Consumption: the pending entry is loaded into stream registers base_r (addr), stride_r, cnt_r (degree), page_r (addr[vaddr-1:12]).
  - e_calc:
    - Compute: next = base_r + stride_r, modulo 2^vaddr_width_p; base_r <= next; cnt_r--.
    - Page cross: next[vaddr-1:12] != page_r → stream ends (e_idle, or reload if pending).
    - Else: e_req with pf_addr_o = next with block-offset bits zeroed.
  - e_req:
    - pf_v_o=1; pf_addr_o is held stable until accepted.
    - On accept, in priority order:
      - pending → reload stream, e_calc.
      - else cnt_r != 0 → e_calc.
      - else → e_idle.
- Preemption: a pending trigger never disturbs an unaccepted request. It replaces the remaining stream at the next e_calc entry or the next accept.
- Flush: flush_i (any state) → e_idle next cycle, pf_v_o=0, pending cleared. Dropping an unaccepted request is legal; prefetches are hints.
- Simultaneous flush_i and stride_v_i: flush wins; the trigger is discarded.
- Same cycle as accept:
  - A stride_v_i arriving with an accept is captured.
  - That trigger is consumed in the following cycle (e_calc one cycle later).

## Timing
- Reset values: pf_v_o=0, pf_addr_o=0, busy_o=0, state e_idle, pending cleared.
- Latency: trigger sampled at edge T in e_idle → e_calc during T+1 → pf_v_o during T+2.
- Throughput with ready held high: one request every 2 cycles (e_calc/e_req alternate).
- busy_o is registered-state derived: no combinational path from stride_v_i or pf_ready_and_i.
- All outputs are driven from registers.

## Configuration
- Macro: BP_BE_PREFETCH_DEDUP_EN.
- Defined:
  - Check: e_calc compares the block address of next against the last block issued, or the trigger block if none has been issued for this stream.
  - On match: skip the request; cnt_r still decrements and the FSM stays in e_calc or exits.
- Undefined: every in-page step issues, including duplicate blocks.

## Structure
- bp_be_pkg additions:
  - bp_be_pf_state_e {e_idle, e_calc, e_req}.
  - bp_be_pf_trigger_s {pc, addr, stride, degree}, plus a width macro.
  - Page offset constant 12.
- Sub-module bp_be_pf_trigger_buffer: one-entry overwrite buffer with set/consume/clear ports; set wins over consume in the same cycle.

## Test plan
- Defaults: 64 B blocks, degree_p=2, confirm_degree_p=4.
- Basic stream: addr 0x1000, stride 0x40, no flags, ready=1 → pf 0x1040 at T+2, 0x1080 at T+4; busy_o low at T+5.
- Negative stride, confirmed: addr 0x2400, stride 0x80 (−128), confirm=1 → 0x2380, 0x2300, 0x2280, 0x2200, then idle.
- Page cross: addr 0x1F80, stride 0x40 → only 0x1FC0 issued; 0x2000 suppressed; e_idle.
- Stall then preempt:
  - Stimulus: ready=0 for 5 cycles on 0x1040; new trigger 0x8000/0x40 during the stall.
  - Response: 0x1040 is held stable; after accept, next is 0x8040, and 0x1080 is never issued.
- Flush: flush_i during e_req of the first request → pf_v_o=0 next cycle, busy_o=0, no further requests.
- Dedup: addr 0x1000, stride 0x10 → with BP_BE_PREFETCH_DEDUP_EN no requests; without it, two requests, both 0x1000.
